// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared constants for the forwarding/hazard unit
//
// Purpose: bypass-select encoding and pipeline stage index names used by
//          fwd_hazard_unit and fwd_match.
// Ports:   none (package).
package fwd_hazard_unit_pkg;

  // byp_sel value meaning "take the operand from the register file";
  // any other value k+1 means "forward from tracked stage k".
  localparam int SEL_RF = 0;

  // Tracked stage indices after ID.
  localparam int STG_EX = 0;
  localparam int STG_DM = 1;
  localparam int STG_WB = 2;

  // Width of the saturating stall counter.
  localparam int CNT_W = 16;

endpackage

// File: rtl/fwd_hazard_unit_fwd_match.sv
// rtl/fwd_hazard_unit_fwd_match.sv - per-read-port youngest-producer matcher
//
// Purpose: for one ID read port, find the youngest tracked stage whose
//          instruction writes the port's source register.
// Ports:   re       - port read enable
//          src      - port source register address
//          tbl_vld  - per-stage valid bits (bit k = stage k)
//          tbl_we   - per-stage write-enable bits
//          tbl_ld   - per-stage load bits
//          tbl_dst  - per-stage destination addresses, packed AW bits per stage
//          hit      - some stage matches
//          k        - index of the youngest matching stage
//          is_ld    - the youngest matching stage holds a load
module fwd_match #(
  parameter int AW    = 4,
  parameter int DEPTH = 3,
  parameter int KW    = 2
) (
  input  logic               re,
  input  logic [AW-1:0]      src,
  input  logic [DEPTH-1:0]   tbl_vld,
  input  logic [DEPTH-1:0]   tbl_we,
  input  logic [DEPTH-1:0]   tbl_ld,
  input  logic [DEPTH*AW-1:0] tbl_dst,
  output logic               hit,
  output logic [KW-1:0]      k,
  output logic               is_ld
);

  // Scan oldest to youngest so the lowest matching index wins.
  // R0 is hard-wired zero, so a read of R0 never forwards.
  always_comb begin
    hit   = 1'b0;
    k     = '0;
    is_ld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (re && (src != '0) && tbl_vld[i] && tbl_we[i] &&
          (tbl_dst[i*AW +: AW] == src)) begin
        hit   = 1'b1;
        k     = KW'(i);
        is_ld = tbl_ld[i];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard unit
//
// Purpose: tracks in-flight writers after ID, selects a bypass source per ID
//          read port, stalls on load-use, and handles halt/drain.
// Ports:   clk, rst_n         - clock, asynchronous active-low reset
//          id_vld             - ID holds a valid instruction
//          id_we, id_ld       - ID instruction writes the RF / is a load
//          id_dst             - ID destination register
//          id_src, id_re      - packed source addresses / per-port read enables
//          flush              - kill the ID instruction this cycle
//          hlt                - ID instruction is a halt
//          stall              - hold IM_ID and insert a bubble into EX
//          byp_sel            - per port: 0 = RF, k+1 = forward from stage k
//          halted, drained    - sticky halt / halted with an empty pipeline
//          stall_cnt          - saturating count of stall cycles
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int NRD    = 2,
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                id_vld,
  input  logic                                id_we,
  input  logic                                id_ld,
  input  logic [$clog2(NREG)-1:0]             id_dst,
  input  logic [NRD*$clog2(NREG)-1:0]         id_src,
  input  logic [NRD-1:0]                      id_re,
  input  logic                                flush,
  input  logic                                hlt,
  output logic                                stall,
  output logic [NRD*$clog2(DEPTH+1)-1:0]      byp_sel,
  output logic                                halted,
  output logic                                drained,
  output logic [CNT_W-1:0]                    stall_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [KW-1:0] LD_LAT_K = KW'(LD_LAT);

  // In-flight instruction table, stage k in bit k.
  logic [DEPTH-1:0]    t_vld;
  logic [DEPTH-1:0]    t_we;
  logic [DEPTH-1:0]    t_ld;
  logic [DEPTH*AW-1:0] t_dst;

  logic [NRD-1:0] hit;
  logic [NRD-1:0] hit_ld;
  logic [NRD-1:0] load_use;
  logic [KW-1:0]  hit_k [NRD];

  logic issue;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .KW    (KW)
    ) u_match (
      .re      (id_re[p]),
      .src     (id_src[p*AW +: AW]),
      .tbl_vld (t_vld),
      .tbl_we  (t_we),
      .tbl_ld  (t_ld),
      .tbl_dst (t_dst),
      .hit     (hit[p]),
      .k       (hit_k[p]),
      .is_ld   (hit_ld[p])
    );

    assign byp_sel[p*SW +: SW] = hit[p] ? (SW'(hit_k[p]) + SW'(1)) : SW'(SEL_RF);

    // Only the youngest producer matters: an older load shadowed by a
    // younger non-load writer never reaches this term.
    assign load_use[p] = hit[p] & hit_ld[p] & (hit_k[p] < LD_LAT_K);
  end

  // flush wins over stall; a flushed instruction is simply dropped.
  assign stall   = id_vld & ~flush & (|load_use);
  assign issue   = id_vld & ~stall & ~flush & ~halted;
  assign drained = halted & ~(|t_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_vld <= '0;
      t_we  <= '0;
      t_ld  <= '0;
      t_dst <= '0;
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        t_vld[i]          <= t_vld[i-1];
        t_we[i]           <= t_we[i-1];
        t_ld[i]           <= t_ld[i-1];
        t_dst[i*AW +: AW] <= t_dst[(i-1)*AW +: AW];
      end
      // Stalled, flushed or post-halt cycles enter EX as a bubble.
      t_vld[STG_EX]           <= issue;
      t_we[STG_EX]            <= id_we;
      t_ld[STG_EX]            <= id_ld;
      t_dst[STG_EX*AW +: AW]  <= id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (id_vld && hlt && !flush && !stall) begin
      halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: defaults (NRD=2, DEPTH=3, LD_LAT=1)
  logic        a_vld, a_we, a_ld, a_fl, a_hlt;
  logic [3:0]  a_dst;
  logic [7:0]  a_src;
  logic [1:0]  a_re;
  logic        a_stall, a_halted, a_drained;
  logic [3:0]  a_sel;
  logic [15:0] a_cnt;

  // DUT B: NRD=3, DEPTH=4, LD_LAT=2
  logic        b_vld, b_we, b_ld, b_fl, b_hlt;
  logic [3:0]  b_dst;
  logic [11:0] b_src;
  logic [2:0]  b_re;
  logic        b_stall, b_halted, b_drained;
  logic [8:0]  b_sel;
  logic [15:0] b_cnt;

  fwd_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .id_vld(a_vld), .id_we(a_we), .id_ld(a_ld),
    .id_dst(a_dst), .id_src(a_src), .id_re(a_re), .flush(a_fl), .hlt(a_hlt),
    .stall(a_stall), .byp_sel(a_sel), .halted(a_halted), .drained(a_drained),
    .stall_cnt(a_cnt)
  );

  fwd_hazard_unit #(.NREG(16), .NRD(3), .DEPTH(4), .LD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_vld(b_vld), .id_we(b_we), .id_ld(b_ld),
    .id_dst(b_dst), .id_src(b_src), .id_re(b_re), .flush(b_fl), .hlt(b_hlt),
    .stall(b_stall), .byp_sel(b_sel), .halted(b_halted), .drained(b_drained),
    .stall_cnt(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each issued instruction is remembered with the cycle number it issued on;
  // its stage at any later cycle is just its age.
  typedef struct {
    int cyc;
    bit we;
    bit ld;
    int dst;
  } ins_t;

  ins_t qa[$];
  ins_t qb[$];
  int   cyc = 0;
  bit   hal_a, hal_b;
  int   cnt_a, cnt_b;

  function automatic void mdl(input ins_t q[$], input int now, input int depth,
                              input int ldlat, input int nrd, input bit vld,
                              input bit fl, input bit [2:0] re, input int src[3],
                              output bit st, output int sel[3]);
    st = 0;
    for (int p = 0; p < 3; p++) begin
      int best;
      bit bld;
      best = -1;
      bld  = 0;
      if (p < nrd && re[p] && src[p] != 0) begin
        foreach (q[i]) begin
          int s;
          s = now - q[i].cyc - 1;
          if (s >= 0 && s < depth && q[i].we && q[i].dst == src[p] &&
              (best < 0 || s < best)) begin
            best = s;
            bld  = q[i].ld;
          end
        end
      end
      sel[p] = best + 1;
      if (best >= 0 && bld && best < ldlat && vld && !fl) st = 1;
    end
  endfunction

  function automatic bit live(input ins_t q[$], input int now, input int depth);
    foreach (q[i]) if (now - q[i].cyc - 1 < depth) return 1;
    return 0;
  endfunction

  function automatic void srcs(input logic [11:0] packed_src, output int s[3]);
    for (int p = 0; p < 3; p++) s[p] = int'(packed_src[p*4 +: 4]);
  endfunction

  // Model update on the active edge (inputs are stable there).
  always @(posedge clk) begin
    bit st;
    int sel[3];
    int s[3];
    if (!rst_n) begin
      qa.delete(); qb.delete();
      hal_a = 0; hal_b = 0; cnt_a = 0; cnt_b = 0;
    end else begin
      srcs({4'b0, a_src}, s);
      mdl(qa, cyc, 3, 1, 2, a_vld, a_fl, {1'b0, a_re}, s, st, sel);
      if (st && cnt_a < 65535) cnt_a++;
      if (a_vld && !st && !a_fl && !hal_a) qa.push_back('{cyc, a_we, a_ld, int'(a_dst)});
      if (a_vld && a_hlt && !a_fl && !st) hal_a = 1;

      srcs(b_src, s);
      mdl(qb, cyc, 4, 2, 3, b_vld, b_fl, b_re, s, st, sel);
      if (st && cnt_b < 65535) cnt_b++;
      if (b_vld && !st && !b_fl && !hal_b) qb.push_back('{cyc, b_we, b_ld, int'(b_dst)});
      if (b_vld && b_hlt && !b_fl && !st) hal_b = 1;
      cyc++;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    bit st;
    int sel[3];
    int s[3];
    if (!rst_n) begin
      qa.delete(); qb.delete();
      hal_a = 0; hal_b = 0; cnt_a = 0; cnt_b = 0;
      check("a_rst_stall", a_stall, 0);
      check("a_rst_sel", a_sel, 0);
      check("a_rst_drained", a_drained, 0);
      check("a_rst_halted", a_halted, 0);
      check("a_rst_cnt", a_cnt, 0);
      check("b_rst_stall", b_stall, 0);
      check("b_rst_sel", b_sel, 0);
      check("b_rst_drained", b_drained, 0);
    end else begin
      srcs({4'b0, a_src}, s);
      mdl(qa, cyc, 3, 1, 2, a_vld, a_fl, {1'b0, a_re}, s, st, sel);
      check("a_stall", a_stall, st);
      if (!st) for (int p = 0; p < 2; p++) check("a_sel", a_sel[p*2 +: 2], sel[p]);
      check("a_halted", a_halted, hal_a);
      check("a_drained", a_drained, hal_a && !live(qa, cyc, 3));
      check("a_cnt", a_cnt, cnt_a);

      srcs(b_src, s);
      mdl(qb, cyc, 4, 2, 3, b_vld, b_fl, b_re, s, st, sel);
      check("b_stall", b_stall, st);
      if (!st) for (int p = 0; p < 3; p++) check("b_sel", b_sel[p*3 +: 3], sel[p]);
      check("b_halted", b_halted, hal_b);
      check("b_drained", b_drained, hal_b && !live(qb, cyc, 4));
      check("b_cnt", b_cnt, cnt_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input bit v, input bit we, input bit ld, input bit h, input bit fl,
                       input int dst, input int s0, input int s1, input bit [1:0] re);
    a_vld = v; a_we = we; a_ld = ld; a_hlt = h; a_fl = fl;
    a_dst = 4'(dst); a_src = {4'(s1), 4'(s0)}; a_re = re;
  endtask

  task automatic drv_b(input bit v, input bit we, input bit ld, input bit h, input bit fl,
                       input int dst, input int s0, input int s1, input int s2,
                       input bit [2:0] re);
    b_vld = v; b_we = we; b_ld = ld; b_hlt = h; b_fl = fl;
    b_dst = 4'(dst); b_src = {4'(s2), 4'(s1), 4'(s0)}; b_re = re;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    #2;
    check("lit_rst_stall", a_stall, 0);
    check("lit_rst_sel", a_sel, 0);
    check("lit_rst_cnt", a_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // ADD R3 ; ADD R4,R3,R3 -> forward from EX on both ports
    drv_a(1, 1, 0, 0, 0, 3, 1, 2, 2'b11); tick();
    drv_a(1, 1, 0, 0, 0, 4, 3, 3, 2'b11); #2;
    check("lit_alu_stall", a_stall, 0);
    check("lit_alu_sel", a_sel, 4'b0101);
    tick();

    // LW R5 ; ADD R6,R5,R1 -> one stall, then forward from DM
    drv_a(1, 1, 1, 0, 0, 5, 1, 0, 2'b01); tick();
    drv_a(1, 1, 0, 0, 0, 6, 5, 1, 2'b11); #2;
    check("lit_lu_stall", a_stall, 1);
    tick(); #2;
    check("lit_lu_stall2", a_stall, 0);
    check("lit_lu_sel", a_sel, 4'b0010);
    check("lit_lu_cnt", a_cnt, 1);
    tick();

    // LW R5 ; ADD R5 ; use R5 -> younger ALU writer wins, no stall
    drv_a(1, 1, 1, 0, 0, 5, 1, 0, 2'b01); tick();
    drv_a(1, 1, 0, 0, 0, 5, 1, 2, 2'b11); tick();
    drv_a(1, 1, 0, 0, 0, 7, 5, 0, 2'b11); #2;
    check("lit_shadow_stall", a_stall, 0);
    check("lit_shadow_sel", a_sel, 4'b0001);
    tick();

    // writer of R0 then reader of R0 -> RF
    drv_a(1, 1, 0, 0, 0, 0, 1, 2, 2'b00); tick();
    drv_a(1, 1, 0, 0, 0, 9, 0, 0, 2'b11); #2;
    check("lit_r0_sel", a_sel, 0);
    check("lit_r0_stall", a_stall, 0);
    tick();

    // LW R8 ; flushed consumer (dst R10) ; then R10/R8 reader
    drv_a(1, 1, 1, 0, 0, 8, 1, 2, 2'b00); tick();
    drv_a(1, 1, 0, 0, 1, 10, 8, 8, 2'b11); #2;
    check("lit_flush_stall", a_stall, 0);
    tick();
    drv_a(1, 1, 0, 0, 0, 11, 10, 8, 2'b11); #2;
    check("lit_flush_sel", a_sel, 4'b1000);
    tick();

    // HLT, then later issue must not be tracked
    drv_a(1, 0, 0, 1, 0, 0, 0, 0, 2'b00); tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 2'b00); #2;
    check("lit_halted", a_halted, 1);
    check("lit_not_drained", a_drained, 0);
    tick();
    drv_a(1, 1, 0, 0, 0, 12, 1, 2, 2'b00); tick();
    drv_a(1, 1, 0, 0, 0, 13, 12, 0, 2'b01); #2;
    check("lit_post_halt_sel", a_sel, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 2'b00); #2;
    check("lit_drained", a_drained, 1);
    tick();

    // reset clears halt/counter; reset mid-stall drops the load-use
    rst_n = 1'b0; #2;
    check("lit_rst2_halted", a_halted, 0);
    check("lit_rst2_cnt", a_cnt, 0);
    tick();
    rst_n = 1'b1;
    drv_a(1, 1, 1, 0, 0, 5, 1, 2, 2'b00); tick();
    drv_a(1, 1, 0, 0, 0, 6, 5, 5, 2'b11); #2;
    check("lit_pre_rst_stall", a_stall, 1);
    rst_n = 1'b0; #1;
    check("lit_mid_rst_stall", a_stall, 0);
    check("lit_mid_rst_sel", a_sel, 0);
    tick();
    rst_n = 1'b1; #2;
    check("lit_post_rst_stall", a_stall, 0);
    check("lit_post_rst_sel", a_sel, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // DUT B: LD_LAT=2 -> two stall cycles, then forward from stage 2
    drv_b(1, 1, 1, 0, 0, 5, 1, 2, 3, 3'b000); tick();
    drv_b(1, 1, 0, 0, 0, 6, 5, 1, 5, 3'b111); #2;
    check("lit_b_stall1", b_stall, 1);
    tick(); #2;
    check("lit_b_stall2", b_stall, 1);
    tick(); #2;
    check("lit_b_stall3", b_stall, 0);
    check("lit_b_sel", b_sel, 9'b011_000_011);
    check("lit_b_cnt", b_cnt, 2);
    tick();

    // DUT B halt and drain
    drv_b(1, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000); tick();
    drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 4; i++) tick();
    #2;
    check("lit_b_drained", b_drained, 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NREG, default 16: architectural register count; AW = clog2(NREG).
REQ-002 Parameter NRD, default 2: number of ID-stage read ports.
REQ-003 Parameter DEPTH, default 3: tracked stages after ID; index 0=EX, 1=DM, 2=WB.
REQ-004 Parameter LD_LAT, default 1: lowest stage index at which load data is bypassable; legal range 0..DEPTH-1.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 id_vld  in  1  ID holds a valid instruction.
REQ-008 id_we, id_ld  in  1 each  ID instruction writes the RF; ID instruction is a load.
REQ-009 id_dst  in  AW  ID destination register.
REQ-010 id_src  in  NRD*AW  packed source addresses; id_re  in  NRD  per-port read enables.
REQ-011 flush  in  1  kill the ID instruction this cycle (taken branch/jump).
REQ-012 hlt  in  1  ID instruction is a halt.
REQ-013 stall  out  1  hold IM_ID; insert a bubble into EX.
REQ-014 byp_sel  out  NRD*clog2(DEPTH+1)  per port: 0 = RF, k+1 = forward from stage k.
REQ-015 halted  out  1  sticky halt seen; drained  out  1  halted and no valid entries remain.
REQ-016 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-017 Internal table: DEPTH entries of {vld, we, ld, dst}; every cycle entry k moves to k+1 and entry DEPTH-1 is discarded.
REQ-018 Entry 0 loads {id_vld & id_we-valid, id_we, id_ld, id_dst} when id_vld & !stall & !flush & !halted; otherwise it loads a bubble (vld=0).
REQ-019 A port p matches stage k when id_re[p], entry k vld & we, dst == src[p], and src[p] != 0.
REQ-020 byp_sel[p] selects the lowest matching k (youngest producer); 0 when no stage matches.
REQ-021 Load-use: stall = 1 when any port's youngest match k has ld=1 and k < LD_LAT, gated by id_vld & !flush.
REQ-022 While stall = 1, byp_sel is don't-care and stall_cnt does not see the stall as a retire; the ID instruction re-evaluates next cycle.
REQ-023 stall and byp_sel are combinational from the table and ID inputs, valid in the same cycle.
REQ-024 With LD_LAT=1, a load in EX followed by a dependent consumer produces exactly 1 stall cycle, then byp_sel = 2 (DM).
REQ-025 A load at k < LD_LAT shadowed by a younger non-load writer to the same register produces no stall; the younger writer wins.
REQ-026 Writes to R0 are tracked but never matched (REQ-019).
REQ-027 flush has priority over stall: a flushed ID instruction never stalls and never enters the table.
REQ-028 hlt with id_vld & !flush & !stall sets halted; once halted, all new issue is suppressed until reset.
REQ-029 drained = halted & no entry vld; it asserts DEPTH cycles after the halt enters EX, at the latest.
REQ-030 stall_cnt increments on each cycle stall = 1 and holds at 16'hFFFF.

Reset
REQ-031 On rst_n low, asynchronously: all table vld = 0, halted = 0, stall_cnt = 0.
REQ-032 During and after reset: stall = 0, byp_sel = 0, drained = 0.
REQ-033 Reset mid-stall discards the pending load-use; the first post-reset issue sees an empty table.

Structure
REQ-034 byp_sel encoding constants (SEL_RF=0) and stage index names (STG_EX, STG_DM, STG_WB) live in the shared common params include.
REQ-035 One sub-module, fwd_match, is instantiated NRD times: a per-port priority matcher producing {hit, k, is_ld}.

Verification
REQ-036 ADD R3 then ADD R4,R3,R3 back-to-back -> stall=0, byp_sel[0]=byp_sel[1]=1 (EX).
REQ-037 LW R5 then ADD R6,R5,R1 (LD_LAT=1) -> 1 stall cycle, stall_cnt=1, then byp_sel[0]=2.
REQ-038 LW R5, ADD R5, then a consumer of R5 -> no stall, byp_sel=1.
REQ-039 Consumer of R0 behind a writer of R0 -> byp_sel=0, stall=0; flush on a load-use cycle -> stall=0 and the entry is not written.
REQ-040 HLT issued -> halted=1 next cycle; drained=1 within 3 cycles (DEPTH=3); a later id_vld is never tracked.
REQ-041 Parameter sweep NRD=3, DEPTH=4, LD_LAT=2: load then dependent consumer -> 2 stall cycles, then byp_sel=3.
